// File: rtl/uc_pkg.sv
// Shared types for the inverse shift unit.
//   op_e    : 3-bit operation code of the original shift whose effect is undone
//   state_e : controller states of unidad_corrimiento_inversa
package uc_pkg;

  typedef enum logic [2:0] {
    TRANSF = 3'b000,
    SHL    = 3'b001,
    SHR    = 3'b010,
    CERO   = 3'b011,
    ROL    = 3'b100,
    ROR    = 3'b101,
    ASL    = 3'b110,
    ASR    = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/uc_paso_inverso.sv
// One-position inverse step: undoes a single position of the original op.
// Ports:
//   s      : current word (N bits)
//   op     : original op code (3 bits, uc_pkg::op_e encoding)
//   s_next : word after one inverse step (N bits)
// The arithmetic inverses treat bit N-1 as a sign bit that never moves.
// N must be at least 2.
module uc_paso_inverso
  import uc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] s,
  input  logic [2:0]   op,
  output logic [N-1:0] s_next
);

  logic [N-2:0] mag_right;
  logic [N-2:0] mag_left;

  assign mag_right = s[N-2:0] >> 1;
  assign mag_left  = s[N-2:0] << 1;

  always_comb begin
    s_next = s;
    case (op_e'(op))
      SHL:     s_next = s >> 1;
      SHR:     s_next = s << 1;
      CERO:    s_next = '0;
      ROL:     s_next = {s[0], s[N-1:1]};
      ROR:     s_next = {s[N-2:0], s[N-1]};
      ASL:     s_next = {s[N-1], mag_right};
      ASR:     s_next = {s[N-1], mag_left};
      default: s_next = s;
    endcase
  end

endmodule

// File: rtl/unidad_corrimiento_inversa.sv
// Inverse shift unit: restores a word that was shifted D positions by op H,
// applying one inverse step per clock.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   start      : request, sampled only in IDLE
//   abort      : (only with UC_INV_ABORT_EN) leave SHIFT without done
//   F, H, D    : shifted word, original op code, original shift count
//   busy, done : busy in SHIFT/DONE, done is a one-cycle pulse
//   S          : restored word, held from DONE until the next accepted start
// Optional feature macro: UC_INV_ABORT_EN
//
// state | meaning
// IDLE  | waiting for start, S holds last result
// SHIFT | one inverse step per cycle, counter counts down to 1
// DONE  | result valid, done pulse, back to IDLE
module unidad_corrimiento_inversa
  import uc_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = (N - 1) / 2 + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef UC_INV_ABORT_EN
  input  logic          abort,
`endif
  input  logic [N-1:0]  F,
  input  logic [2:0]    H,
  input  logic [DW-1:0] D,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  S
);

  state_e        state_q, state_d;
  logic [N-1:0]  s_q, s_d;
  op_e           op_q, op_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  s_step;

  uc_paso_inverso #(.N(N)) u_paso (
    .s      (s_q),
    .op     (op_q),
    .s_next (s_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      op_q    <= TRANSF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = F;
          op_d    = op_e'(H);
          cnt_d   = D;
          state_d = (D == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        s_d   = s_step;
        cnt_d = cnt_q - DW'(1);
        if (cnt_q == DW'(1)) state_d = DONE;
`ifdef UC_INV_ABORT_EN
        // The step of the aborting cycle still lands; only completion is dropped.
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign S    = s_q;

endmodule

// File: doc/unidad_corrimiento_inversa.md
UNIDAD_CORRIMIENTO_INVERSA -- requirements
Module: unidad_corrimiento_inversa

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits.
REQ-002 SHALL have parameter DW, default (N-1)/2+1, giving the shift-count width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-006 SHALL have port F, input, N bits: the previously shifted word to be restored.
REQ-007 SHALL have port H, input, 3 bits: the original operation code whose inverse is applied.
REQ-008 SHALL have port D, input, DW bits: the original shift count.
REQ-009 SHALL have port busy, output, 1 bit: high in SHIFT and DONE states.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port S, output, N bits: the restored word.

Function
REQ-012 SHALL implement three FSM states: IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE with start=1, capture F into S, capture H and D into internal registers, and load a step counter with D.
REQ-014 SHALL go IDLE->SHIFT on start if D!=0, and IDLE->DONE on start if D==0, with S=F unchanged in that case.
REQ-015 SHALL, in SHIFT, apply exactly one inverse step to S and decrement the counter each cycle, moving to DONE when the counter reaches 1.
REQ-016 SHALL use these inverse steps:
- 001 (shl): logical right 1.
- 010 (shr): logical left 1.
- 100 (rol): rotate right 1.
- 101 (ror): rotate left 1.
- 110 (asl): keep S[N-1], logical right 1 of S[N-2:0].
- 111 (asr): keep S[N-1], logical left 1 of S[N-2:0].
REQ-017 SHALL set S to all zeros in the first SHIFT cycle for op 011 and hold zero thereafter; total latency still follows D.
REQ-018 SHALL treat op 000 and any other transfer code as a hold of S for D cycles.
REQ-019 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-020 SHALL give a latency from the start edge to the done=1 cycle of D+1 clocks (1 clock when D=0).
REQ-021 SHALL hold S stable from DONE until the next accepted start.
REQ-022 SHALL ignore start while busy=1, leaving the captured operands unaffected.
REQ-023 SHALL accept start in the cycle immediately after DONE, giving back-to-back operation.
REQ-024 SHALL use the full unsigned range of D (maximum 2^DW-1), with rotates wrapping modulo N naturally.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-SHIFT, immediately force state IDLE, S=0, busy=0, done=0 and counter=0.
REQ-026 SHALL, after rst_n deasserts, accept a start on the first clock edge.

Configuration
REQ-027 SHALL, with UC_INV_ABORT_EN defined, add input abort (1 bit): abort=1 in SHIFT moves to IDLE next cycle, keeps S at its partial value, and does not pulse done.
REQ-028 SHALL, without UC_INV_ABORT_EN, have no abort port, and every accepted start SHALL end in done.

Structure
REQ-029 SHALL take from shared package uc_pkg the op-code enum typedef (3 bits: TRANSF, SHL, SHR, CERO, ROL, ROR, ASL, ASR) and the FSM state typedef.
REQ-030 SHALL isolate the one-position inverse step in combinational sub-module uc_paso_inverso (inputs S and op, output next S), parameterised by N.

Verification
REQ-031 SHALL cover: N=4, F=0110, H=100, D=1 -> done on cycle 2, S=0011.
REQ-032 SHALL cover: F=1000, H=001, D=3 -> done after 4 clocks, S=0001.
REQ-033 SHALL cover: F=1010, H=110, D=1 -> S=1001; and F=1100, H=111, D=1 -> S=1000.
REQ-034 SHALL cover: D=0, F=0101 with any H -> done on the next clock, S=0101; start reasserted during busy -> ignored, with no second done.
REQ-035 SHALL cover: rst_n pulled low in mid-SHIFT of F=1111, H=101, D=3 -> S=0, busy=0, done=0 at once, then a clean new operation completes.
REQ-036 SHALL cover, with UC_INV_ABORT_EN: abort in the second SHIFT cycle of F=0001, H=010, D=3 -> IDLE, S=0100, no done pulse.
